// File: rtl/axi_lite_master.sv
// axi_lite_master: turns a valid/ready command port into single AXI4-Lite
// read or write transactions, one outstanding at a time, and returns the
// result on a valid/ready response port with a saturating error counter.
//
// state   | meaning
// --------+-------------------------------------------
// IDLE    | waiting for a command, cmd_ready high
// WR      | AW and W in flight, each drops on its own handshake
// WR_RESP | BREADY high, waiting for BVALID
// RD_ADDR | ARVALID high, waiting for ARREADY
// RD_DATA | RREADY high, waiting for RVALID
// RESP    | rsp_valid high, waiting for rsp_ready
module axi_lite_master #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [15:0]             err_count,

  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t                    state_q, state_nxt;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic                      aw_pend_q, w_pend_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [1:0]                resp_q;
  logic [15:0]               err_q;

  // State register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= IDLE;
    else              state_q <= state_nxt;
  end

  // Next-state decode; write phase ends once both AW and W have handshaken.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_nxt = cmd_write ? WR : RD_ADDR;
      WR:      if ((!aw_pend_q || M_AXI_AWREADY) && (!w_pend_q || M_AXI_WREADY))
                 state_nxt = WR_RESP;
      WR_RESP: if (M_AXI_BVALID)  state_nxt = RESP;
      RD_ADDR: if (M_AXI_ARREADY) state_nxt = RD_DATA;
      RD_DATA: if (M_AXI_RVALID)  state_nxt = RESP;
      RESP:    if (rsp_ready)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture, per-channel write valids, response capture and error count.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      err_q     <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          addr_q    <= cmd_addr;
          wdata_q   <= cmd_wdata;
          wstrb_q   <= cmd_wstrb;
          aw_pend_q <= cmd_write;
          w_pend_q  <= cmd_write;
        end
        WR: begin
          if (M_AXI_AWREADY) aw_pend_q <= 1'b0;
          if (M_AXI_WREADY)  w_pend_q  <= 1'b0;
        end
        WR_RESP: if (M_AXI_BVALID) begin
          rdata_q <= '0;
          resp_q  <= M_AXI_BRESP;
          if (M_AXI_BRESP != 2'b00 && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        end
        RD_DATA: if (M_AXI_RVALID) begin
          rdata_q <= M_AXI_RDATA;
          resp_q  <= M_AXI_RRESP;
          if (M_AXI_RRESP != 2'b00 && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // cmd_ready is gated by reset so it drops in the same cycle reset asserts.
  assign cmd_ready     = (state_q == IDLE) && axi_aresetn;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign err_count     = err_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = aw_pend_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = w_pend_q;
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state_q == RD_ADDR);
  assign M_AXI_RREADY  = (state_q == RD_DATA);

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: directed cases plus randomized transactions
// against a register-file slave model and an expected-response queue.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [39:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_count;
  logic [39:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axi_lite_master #(.ADDR_WIDTH(40), .DATA_WIDTH(32)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .err_count(err_count),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [15:0] err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [0:15];
  logic [15:0] model_err;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response checker: every cycle rsp_valid is high, outputs must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got rsp_valid 1 expected 0 at %0t", $time);
      end else begin
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
        chk("rsp_resp", 64'(rsp_resp), 64'(exp_q[0].resp));
        chk("err_count", 64'(err_count), 64'(exp_q[0].err));
      end
    end
  end

  // Retire the expected entry on the response handshake.
  always @(posedge clk) begin
    if (rst_n && rsp_valid && rsp_ready && exp_q.size() > 0) exp_q.delete(0);
  end

  // One command end to end; this task also plays the slave. d1/d2 are AW/W
  // (or AR/R) ready delays, d3 the B delay, rdly the rsp_ready delay.
  task automatic run_cmd(input bit wr, input logic [39:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int d1, input int d2, input int d3,
                         input logic [1:0] resp, input int rdly, input bit abort,
                         output int rsp_cyc, output logic [31:0] got_rdata);
    int   cyc, k;
    bit   aw_done, w_done, hs, first;
    exp_t e;
    logic [3:0] idx;
    idx = addr[5:2];
    rsp_cyc = -1;
    got_rdata = 32'hx;
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    e.rdata = wr ? 32'h0 : mem[idx];
    e.resp  = resp;
    if (resp != 2'b00 && model_err != 16'hFFFF) model_err = model_err + 16'd1;
    e.err = model_err;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    if (wr) begin
      aw_done = 0; w_done = 0; k = 0;
      while (!(aw_done && w_done)) begin
        chk("awvalid", 64'(awvalid), 64'(!aw_done));
        chk("wvalid", 64'(wvalid), 64'(!w_done));
        chk("bready_early", 64'(bready), 64'(0));
        if (!aw_done) chk("awaddr", 64'(awaddr), 64'(addr));
        if (!w_done) begin
          chk("wdata", 64'(wdata), 64'(data));
          chk("wstrb", 64'(wstrb), 64'(strb));
        end
        awready = !aw_done && k >= d1;
        wready  = !w_done && k >= d2;
        @(negedge clk); cyc++; k++;
        if (awready) aw_done = 1;
        if (wready) w_done = 1;
        awready = 1'b0; wready = 1'b0;
      end
      k = 0;
      do begin
        chk("bready", 64'(bready), 64'(1));
        chk("awvalid_late", 64'(awvalid | wvalid), 64'(0));
        bvalid = (k >= d3); bresp = resp; hs = bvalid;
        @(negedge clk); cyc++; k++;
        bvalid = 1'b0; bresp = 2'b00;
      end while (!hs);
      if (resp == 2'b00)
        for (int b = 0; b < 4; b++) if (strb[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
    end else begin
      k = 0;
      do begin
        chk("arvalid", 64'(arvalid), 64'(1));
        chk("araddr", 64'(araddr), 64'(addr));
        chk("rready_early", 64'(rready), 64'(0));
        arready = (k >= d1); hs = arready;
        @(negedge clk); cyc++; k++;
        arready = 1'b0;
      end while (!hs);
      k = 0;
      do begin
        chk("rready", 64'(rready), 64'(1));
        chk("arvalid_late", 64'(arvalid), 64'(0));
        if (abort) begin
          rst_n = 1'b0;
          #1;
          chk("rst_arvalid", 64'(arvalid), 64'(0));
          chk("rst_rready", 64'(rready), 64'(0));
          chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
          chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
          exp_q.delete();
          model_err = 16'h0000;
          @(negedge clk);
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
          chk("post_rst_err", 64'(err_count), 64'(0));
          chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
          return;
        end
        rvalid = (k >= d2); rresp = resp; rdata = mem[idx]; hs = rvalid;
        @(negedge clk); cyc++; k++;
        rvalid = 1'b0; rresp = 2'b00; rdata = $urandom;
      end while (!hs);
    end
    k = 0; first = 1;
    do begin
      chk("rsp_valid", 64'(rsp_valid), 64'(1));
      chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
      if (first) begin rsp_cyc = cyc; got_rdata = rsp_rdata; end
      first = 0;
      rsp_ready = (k >= rdly); hs = rsp_ready;
      @(negedge clk); cyc++; k++;
      rsp_ready = 1'b0;
    end while (!hs);
    chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rc;
    logic [31:0] rd;
    logic [3:0]  idx;
    logic [1:0]  rsp;
    rst_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    model_err = 16'h0000;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'hDEADBEEF;

    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("reset_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'(0));
    chk("reset_rsp", 64'({rsp_rdata, rsp_resp}), 64'(0));
    chk("reset_err", 64'(err_count), 64'(0));
    chk("reset_addr", 64'({awaddr, wstrb}), 64'(0));
    chk("reset_prot", 64'({awprot, arprot}), 64'(0));
    rst_n = 1'b1;

    // Zero-wait write, then zero-wait read of the preloaded word.
    run_cmd(1, 40'h08, 32'h0000_0003, 4'hF, 0, 0, 0, 2'b00, 0, 0, rc, rd);
    chk("wr_rsp_cycle", 64'(rc), 64'(3));
    chk("wr_rdata_zero", 64'(rd), 64'(0));
    run_cmd(0, 40'h00, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 0, rc, rd);
    chk("rd_rsp_cycle", 64'(rc), 64'(3));
    chk("rd_deadbeef", 64'(rd), 64'h0000_0000_DEAD_BEEF);
    run_cmd(0, 40'h08, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 0, rc, rd);
    chk("rd_back_08", 64'(rd), 64'h3);

    // Skewed write channels in both directions.
    run_cmd(1, 40'h0C, 32'hA5A5_5A5A, 4'h5, 0, 5, 1, 2'b00, 0, 0, rc, rd);
    run_cmd(1, 40'h10, 32'h1234_5678, 4'hF, 5, 0, 0, 2'b00, 1, 0, rc, rd);

    // Error read with a slow consumer.
    chk("err_before", 64'(err_count), 64'(0));
    run_cmd(0, 40'h04, 32'h0, 4'h0, 1, 2, 0, 2'b10, 4, 0, rc, rd);
    chk("err_after", 64'(err_count), 64'(1));

    // Reset while waiting for read data, then a normal command.
    run_cmd(0, 40'h14, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 1, rc, rd);
    run_cmd(1, 40'h18, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00, 0, 0, rc, rd);
    chk("post_rst_rsp_cycle", 64'(rc), 64'(3));

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      idx = 4'($urandom_range(0, 15));
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_cmd(1'($urandom), {8'($urandom), 26'd0, idx, 2'b00}, $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              rsp, $urandom_range(0, 3), 0, rc, rd);
    end

    // Saturation of the error counter.
    @(negedge clk);
    force dut.err_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_q;
    model_err = 16'hFFFE;
    @(negedge clk);
    chk("err_forced", 64'(err_count), 64'hFFFE);
    for (int n = 0; n < 3; n++)
      run_cmd(1, 40'h20, 32'h0, 4'hF, 0, 0, 0, 2'b10, 0, 0, rc, rd);
    chk("err_saturated", 64'(err_count), 64'hFFFF);
    chk("exp_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator that turns a simple valid/ready command port into single AXI4-Lite read or write transactions and returns the result on a valid/ready response port. It sits in the PL next to the register files and drives their S_AXI ports directly. Typical uses are PL-side sequencers and self-test logic that need the same register access path software uses, without going through the PS.

## Interface
Parameters:
- ADDR_WIDTH, 40, width of command address and AW/AR address buses.
- DATA_WIDTH, 32, data width; fixed at 32, and the strobe width is DATA_WIDTH/8.

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_aresetn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data (ignored for reads).
- cmd_wstrb  in  4  write byte strobes (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the transaction.
- err_count  out  16  saturating count of responses with resp != 2'b00.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels, with widths from the parameters. AWPROT and ARPROT are tied to 3'b000.

## Operation
- One transaction outstanding at a time, with no pipelining between commands.
- States: IDLE, WR (AW/W in flight), WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - cmd_ready = 1 (forced 0 while axi_aresetn is low).
  - On accept, register addr, wdata and wstrb, then go to WR if cmd_write else RD_ADDR.
- WR:
  - AWVALID and WVALID are both asserted on entry.
  - Each channel drops independently on its own handshake; the channels may complete in either order or the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID, capture BRESP into rsp_resp, set rsp_rdata = 0, go to RESP.
- RD_ADDR: ARVALID = 1; on ARREADY go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID, capture RDATA and RRESP, go to RESP.
- RESP:
  - rsp_valid = 1, with rsp_rdata and rsp_resp held stable.
  - On rsp_ready, go to IDLE.
- err_count:
  - Increments by 1 on entry to RESP when the captured resp != 2'b00.
  - Saturates at 16'hFFFF and never wraps.
- Addresses, data and strobes on AXI are driven from registers and stay stable while the matching VALID is high.
- No VALID deasserts before its handshake completes.

## Timing
- Reset values:
  - State IDLE.
  - All AXI VALID/READY outputs 0; cmd_ready 0 during reset.
  - rsp_valid 0; rsp_rdata 0; rsp_resp 0; err_count 0.
  - Address, data and strobe registers 0.
- All outputs are registered or decoded from the state register only, with no combinational path from AXI inputs to outputs.
- Best-case write (AWREADY, WREADY and BVALID immediate):
  - Accept at cycle 0.
  - AW/W handshake at cycle 1.
  - BREADY/BVALID at cycle 2.
  - rsp_valid at cycle 3.
- Best-case read:
  - Accept at cycle 0.
  - AR handshake at cycle 1.
  - R handshake at cycle 2.
  - rsp_valid at cycle 3.
- After a response handshake in cycle N, cmd_ready = 1 in cycle N+1. The minimum command-to-command spacing is 4 cycles.
- Reset mid-transaction: all outputs return to their reset values immediately (asynchronous), and no response is produced for the aborted command. The slave is reset by the same axi_aresetn.

## Test plan
- Write to a regfile slave model: addr 0x08, data 0x0000_0003, strb 4'hF, with zero-wait slave.
  - Required: AW/W valid at cycle 1, rsp_valid at cycle 3, rsp_resp 2'b00, rsp_rdata 0.
- Read from addr 0x00 on the slave model returning 32'hDEADBEEF.
  - Required: ARADDR 0x00, rsp_rdata 32'hDEADBEEF, rsp_resp 2'b00, rsp_valid at cycle 3.
- Write with WREADY delayed 5 cycles past AWREADY.
  - Required: AWVALID drops after 1 cycle, WVALID holds until its handshake, and BREADY asserts only after both.
  - Repeat with AWREADY delayed instead.
- Read returning RRESP 2'b10 with rsp_ready held low for 4 cycles.
  - Required: rsp_valid and rsp_rdata stable for all 4 cycles, err_count goes 0 to 1, and cmd_ready stays 0 until the cycle after rsp_ready.
- Assert axi_aresetn low while in RD_DATA.
  - Required: ARVALID, RREADY, rsp_valid and cmd_ready all 0 in the same cycle.
  - After release: IDLE with cmd_ready 1, and the next command completes normally.
- Force err_count to 16'hFFFE, then issue 3 SLVERR writes.
  - Required: err_count reads 16'hFFFF and stays there.
